// File: rtl/ocr_result_sequencer.sv
// ocr_result_sequencer: result/status back-end for the OCR FPGA top level.
// It handles reset synchronisation, the heartbeat, and the inference watchdog.
// It also drives a time-multiplexed seven-segment history of the latest
// classifications.
// Optional build macro: TIMEOUT_AUTO_RECOVER_EN. When defined, TIMEOUT returns
// to IDLE once bnn_enable drops. When undefined, only clear or reset leaves TIMEOUT.
module ocr_result_sequencer #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLASS_W        = 4,
  parameter int NUM_CLASSES    = 10,
  parameter int SCAN_DIV       = 1000,
  parameter int HB_DIV         = 25000000,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RST_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n_pin,
  output logic                  rst_n_out,
  input  logic                  bnn_enable,
  input  logic                  result_ready,
  input  logic [CLASS_W-1:0]    result_out,
  input  logic                  clear,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  heartbeat,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [7:0]            result_count
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HB_W   = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
  localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_DIV - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_t;

  state_t                state_q, state_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  terr_d;
  logic                  capture;
  logic [RST_STAGES-1:0] rst_sync;
  logic [SLOT_W-1:0]     slot_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [HB_W-1:0]       hb_cnt;
  logic                  hist_vld [NUM_DIGITS];
  logic [CLASS_W-1:0]    hist_cls [NUM_DIGITS];
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  // Active-low seven-segment glyph {g..a}; invalid or out-of-range classes are blank.
  function automatic logic [6:0] seg_decode(input logic vld, input logic [CLASS_W-1:0] cls);
    logic [6:0] s;
    s = 7'h7F;
    if (vld && (32'(cls) < NUM_CLASSES)) begin
      case (32'(cls))
        0:       s = 7'h40;
        1:       s = 7'h79;
        2:       s = 7'h24;
        3:       s = 7'h30;
        4:       s = 7'h19;
        5:       s = 7'h12;
        6:       s = 7'h02;
        7:       s = 7'h78;
        8:       s = 7'h00;
        9:       s = 7'h10;
        default: s = 7'h7F;
      endcase
    end
    return s;
  endfunction

  // Reset synchroniser: asserts asynchronously and releases after RST_STAGES edges.
  always_ff @(posedge clk or negedge rst_n_pin) begin
    if (!rst_n_pin) rst_sync <= '0;
    else            rst_sync <= {rst_sync[RST_STAGES-2:0], 1'b1};
  end

  assign rst_n_out = rst_sync[RST_STAGES-1];
  assign busy      = (state_q == RUN);

  // FSM and watchdog state registers.
  always_ff @(posedge clk or negedge rst_n_out) begin
    if (!rst_n_out) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      timeout_err <= terr_d;
    end
  end

  // Next state and watchdog. A result beats a timeout, and clear beats everything.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    terr_d  = timeout_err;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (bnn_enable) state_d = RUN;
      end
      RUN: begin
        if (wd_q != WD_LAST) wd_d = wd_q + WD_W'(1);
        if (result_ready) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (wd_q == WD_LAST) begin
          state_d = TIMEOUT;
          terr_d  = 1'b1;
        end
      end
      DONE: begin
        if (!bnn_enable) state_d = IDLE;
      end
      TIMEOUT: begin
`ifdef TIMEOUT_AUTO_RECOVER_EN
        if (!bnn_enable) state_d = IDLE;
`else
        state_d = TIMEOUT;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      terr_d  = 1'b0;
      capture = 1'b0;
    end
  end

  // History shift register (newest in entry 0) and the saturating result counter.
  always_ff @(posedge clk or negedge rst_n_out) begin
    if (!rst_n_out) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist_vld[i] <= 1'b0;
        hist_cls[i] <= '0;
      end
      result_count <= 8'd0;
    end else if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) hist_vld[i] <= 1'b0;
      result_count <= 8'd0;
    end else if (capture) begin
      hist_vld[0] <= 1'b1;
      hist_cls[0] <= result_out;
      for (int i = 1; i < NUM_DIGITS; i++) begin
        hist_vld[i] <= hist_vld[i-1];
        hist_cls[i] <= hist_cls[i-1];
      end
      if (result_count != 8'hFF) result_count <= result_count + 8'd1;
    end
  end

  // Scan slot timer and digit index.
  always_ff @(posedge clk or negedge rst_n_out) begin
    if (!rst_n_out) begin
      slot_p0 <= '0;
      idx_p0  <= '0;
    end else if (slot_p0 == SLOT_LAST) begin
      slot_p0 <= '0;
      idx_p0  <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
    end else begin
      slot_p0 <= slot_p0 + SLOT_W'(1);
    end
  end

  // Glyph and digit enable for the current index; TIMEOUT overrides with 'E' on digit 0.
  always_comb begin
    if (state_q == TIMEOUT) seg_nxt = (idx_p0 == '0) ? 7'h06 : 7'h7F;
    else                    seg_nxt = seg_decode(hist_vld[idx_p0], hist_cls[idx_p0]);
    an_nxt = ~(NUM_DIGITS'(1) << idx_p0);
  end

  // ---- stage p1: segments and anodes registered together so digits never ghost ----
  always_ff @(posedge clk or negedge rst_n_out) begin
    if (!rst_n_out) begin
      seg <= 7'h7F;
      an  <= '1;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

  // Heartbeat divider: toggles each HB_DIV cycles.
  always_ff @(posedge clk or negedge rst_n_out) begin
    if (!rst_n_out) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt    <= '0;
      heartbeat <= ~heartbeat;
    end else begin
      hb_cnt <= hb_cnt + HB_W'(1);
    end
  end

endmodule

// File: doc/ocr_result_sequencer.md
Name: ocr_result_sequencer

Overview:
Parametrised result/status back-end for the OCR FPGA top level. It owns reset synchronisation, heartbeat generation, the inference watchdog, and a multi-digit, time-multiplexed seven-segment history of the last NUM_DIGITS BNN classifications. It sits between bnn_interface/controller_fsm and the board pins.

Parameters:
NUM_DIGITS, 4, display digits and history depth (>=1)
CLASS_W, 4, width of result_out
NUM_CLASSES, 10, valid classes 0..NUM_CLASSES-1; any other value displays blank
SCAN_DIV, 1000, clk cycles per digit scan slot (>=2)
HB_DIV, 25000000, clk cycles per heartbeat toggle (>=1)
TIMEOUT_CYCLES, 65536, maximum RUN cycles without result_ready (>=2)
RST_STAGES, 2, reset synchroniser depth (>=2)

Ports:
clk  in  1  system clock
rst_n_pin  in  1  board reset, asynchronous, active-low
rst_n_out  out  1  synchronised reset distributed to sub-blocks
bnn_enable  in  1  inference request level from controller FSM
result_ready  in  1  single-cycle result strobe
result_out  in  CLASS_W  class index, valid with result_ready
clear  in  1  synchronous clear of history, error and state
seg  out  7  active-low segments {g..a}
an  out  NUM_DIGITS  active-low digit enables
heartbeat  out  1  liveness toggle
busy  out  1  high in RUN
timeout_err  out  1  sticky watchdog error
result_count  out  8  saturating count of captured results

Behaviour:
- Reset: rst_n_pin is asynchronous, active-low; clock is clk. RST_STAGES flops assert asynchronously and release synchronously. rst_n_out is the last stage. All other state is reset asynchronously by rst_n_out. rst_n_out releases RST_STAGES rising edges after rst_n_pin deasserts.
- Reset values: seg=7'h7F, an=all ones, heartbeat=0, busy=0, timeout_err=0, result_count=0, history invalid, FSM=IDLE, scan index 0.
- Reset mid-operation: rst_n_pin low in any state forces all reset values immediately, without waiting for a clock edge.
- FSM states: IDLE, RUN, DONE, TIMEOUT.
  - IDLE -> RUN when bnn_enable=1. The watchdog counter loads 0.
  - RUN: the watchdog counter increments each cycle.
    - result_ready=1 -> capture, then DONE.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES-1 -> TIMEOUT and timeout_err<=1.
    - result_ready and timeout in the same cycle: the result wins.
  - DONE -> IDLE when bnn_enable=0. A new inference needs a fresh enable.
  - TIMEOUT: held until clear (see the optional feature).
- clear=1 in any state:
  - next state is IDLE;
  - timeout_err, history valid bits and result_count are cleared;
  - clear wins over a simultaneous result_ready.
- busy is high exactly while the state is RUN.
- result_ready outside RUN is ignored: no capture, no count.
- Capture:
  - History is a shift register of NUM_DIGITS entries, each {valid, class}.
  - entry[0]<=result_out, entry[i]<=entry[i-1], and the oldest entry drops off.
  - The update is visible one cycle after result_ready.
  - result_count increments per capture and saturates at 255.
- Display scan:
  - The slot counter runs 0..SCAN_DIV-1. At wrap, the digit index advances mod NUM_DIGITS.
  - an and seg are registered together, one cycle after the index changes, so there is no ghosting.
  - Only bit idx of an is low.
  - Digit 0 (rightmost) shows the newest entry.
  - Decode 0-9 (active-low, {g..a}): 40,79,24,30,19,12,02,78,00,10 hex.
  - An invalid entry or class>=NUM_CLASSES shows 7'h7F.
  - In TIMEOUT, digit 0 shows 'E' (7'h06) and the other digits show blank.
- Heartbeat: counter 0..HB_DIV-1; heartbeat toggles at wrap, giving a period of 2*HB_DIV cycles.
- Counters never exceed their terminal value. Width is $clog2 of the relevant parameter, minimum 1.

Optional Feature:
Macro TIMEOUT_AUTO_RECOVER_EN.
- Defined: TIMEOUT -> IDLE when bnn_enable=0. timeout_err stays set until clear. The 'E' display persists only while in TIMEOUT.
- Undefined: TIMEOUT is left only by clear or reset.

Test Plan:
Bench parameters for all scenarios: SCAN_DIV=4, HB_DIV=8, TIMEOUT_CYCLES=16, NUM_DIGITS=4.
- Reset: rst_n_pin low 5 cycles, then high -> all outputs at reset values during the low phase; rst_n_out high at the 2nd rising edge after release; heartbeat first toggles 8 cycles later.
- Capture/shift: four inferences with results 3,7,1,9 -> history {9,1,7,3} newest-first; with an=4'b1110, seg=7'h10; with an=4'b0111, seg=7'h30; result_count=4.
- Watchdog: bnn_enable=1, no result for 16 cycles -> TIMEOUT, timeout_err=1; digit 0 shows 7'h06; a later result_ready does not change result_count.
- Simultaneous events:
  - result_ready on the timeout cycle -> DONE, timeout_err=0.
  - clear with result_ready -> history blank, result_count=0.
- Invalid class and saturation:
  - result_out=12 -> that digit shows 7'h7F.
  - 260 captures -> result_count=255.
- Optional feature: in TIMEOUT, drop bnn_enable -> with TIMEOUT_AUTO_RECOVER_EN, IDLE with timeout_err=1; without it, still in TIMEOUT until clear.
